// File: rtl/seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_pkg - state codes, PRBS7 constants and reference patterns shared by the
//           serial pattern generator and detector blocks.   rev 1.0
// ----------------------------------------------------------------------------
package seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // x^7 + x^6 + 1: feedback taps on bits 6 and 5
  localparam logic [6:0] PRBS7_TAPS = 7'h60;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  localparam logic [3:0] PAT_0110 = 4'b0110;
  localparam logic [3:0] PAT_0111 = 4'b0111;

  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs7_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prbs7_gen - 7-bit Fibonacci LFSR noise source with enable and seed reload.
//             rev 1.0
// ----------------------------------------------------------------------------
module prbs7_gen
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_load,
  output logic o_bit
);

  logic [6:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= PRBS7_SEED;
    end else if (i_load) begin
      r_lfsr <= PRBS7_SEED;
    end else if (i_en) begin
      r_lfsr <= prbs7_next(r_lfsr);
    end
  end

  assign o_bit = r_lfsr[6];

endmodule
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_serializer - MSB-first word serializer with frame markers and idle gap.
//                  Optional idle noise: SEQ_SERIALIZER_PRBS_IDLE_EN.   rev 1.0
// ----------------------------------------------------------------------------
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] c_gap_load = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam bit               c_seamless = (GAP_CYCLES == 0);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gap_nxt;

  logic r_out;
  logic r_valid;
  logic r_start;
  logic r_end;
  logic r_busy;
  logic w_out_nxt;
  logic w_valid_nxt;
  logic w_start_nxt;
  logic w_end_nxt;
  logic w_busy_nxt;

  logic w_lsb;
  logic w_in_ready;
  logic w_accept;

  // The LSB cycle doubles as an accept slot only when frames run seamlessly.
  assign w_lsb      = (r_state == ST_SHIFT) && (r_cnt == '0);
  assign w_in_ready = !flush && ((r_state == ST_IDLE) || (c_seamless && w_lsb));
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_start <= w_start_nxt;
      r_end   <= w_end_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) w_state_nxt = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_cnt == '0) begin
            if (w_accept)       w_state_nxt = ST_SHIFT;
            else if (c_seamless) w_state_nxt = ST_IDLE;
            else                w_state_nxt = ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap == '0) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // r_shift holds only the bits still to be sent; the MSB leaves on accept.
  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_out_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_start_nxt = 1'b0;
    w_end_nxt   = 1'b0;
    if (flush) begin
      w_shift_nxt = '0;
      w_cnt_nxt   = '0;
      w_gap_nxt   = '0;
    end else if (w_accept) begin
      w_shift_nxt = in_data << 1;
      w_cnt_nxt   = c_last_bit;
      w_out_nxt   = in_data[WIDTH-1];
      w_valid_nxt = 1'b1;
      w_start_nxt = 1'b1;
    end else if ((r_state == ST_SHIFT) && (r_cnt != '0)) begin
      w_shift_nxt = r_shift << 1;
      w_cnt_nxt   = r_cnt - CNT_W'(1);
      w_out_nxt   = r_shift[WIDTH-1];
      w_valid_nxt = 1'b1;
      w_end_nxt   = (r_cnt == CNT_W'(1));
    end else if (w_lsb) begin
      w_gap_nxt = c_gap_load;
    end else if ((r_state == ST_GAP) && (r_gap != '0)) begin
      w_gap_nxt = r_gap - GAP_W'(1);
    end
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_valid;
  assign frame_start = r_start;
  assign frame_end   = r_end;
  assign busy        = r_busy;

`ifdef SEQ_SERIALIZER_PRBS_IDLE_EN
  logic w_prbs_en;
  logic w_prbs_bit;

  assign w_prbs_en = (r_state != ST_SHIFT);

  prbs7_gen u_prbs7_gen (
    .clk    (clk),
    .rst_n  (reset),
    .i_en   (w_prbs_en),
    .i_load (1'b0),
    .o_bit  (w_prbs_bit)
  );

  assign out = r_valid ? r_out : w_prbs_bit;
`else
  assign out = r_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// tb_seq_serializer - randomized self-checking bench; three serializers with
// GAP_CYCLES of 0, 1 and 3 checked against a frame-schedule reference model.
module tb_seq_serializer;

  localparam int W    = 4;
  localparam int NDUT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data     [NDUT];
  logic         in_valid    [NDUT];
  logic         flush       [NDUT];
  logic         in_ready    [NDUT];
  logic         out         [NDUT];
  logic         out_valid   [NDUT];
  logic         frame_start [NDUT];
  logic         frame_end   [NDUT];
  logic         busy        [NDUT];

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] q_words [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    seq_serializer #(
      .WIDTH      (W),
      .GAP_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data[g]),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .flush       (flush[g]),
      .out         (out[g]),
      .out_valid   (out_valid[g]),
      .frame_start (frame_start[g]),
      .frame_end   (frame_end[g]),
      .busy        (busy[g])
    );
  end

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic idle_all();
    for (int k = 0; k < NDUT; k++) begin
      in_valid[k] = 1'b0;
      flush[k]    = 1'b0;
      in_data[k]  = '0;
    end
  endtask

  // Expected behaviour derived from accept times: word i is accepted at a[i],
  // its bits occupy a[i]+1..a[i]+W, the block stays busy through the gap.
  task automatic run_stream(input int k, input string name, input bit rnd);
    int a[$];
    int s[$];
    int g_cyc, prev_a, base, si, fi, ai, total;
    logic [W-1:0] wi;
    logic ev, eo, fs, fe, eb, er, lsb;
    g_cyc  = gap_of(k);
    prev_a = 0;
    for (int i = 0; i < q_words.size(); i++) begin
      base = (i == 0) ? 0 : prev_a + 1;
      si   = base + (rnd ? int'($urandom_range(0, W + 3)) : 0);
      fi   = (i == 0) ? 0 : prev_a + W + ((g_cyc > 0) ? g_cyc + 1 : 0);
      ai   = (si > fi) ? si : fi;
      s.push_back(si);
      a.push_back(ai);
      prev_a = ai;
    end
    total = prev_a + W + g_cyc + 3;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      in_valid[k] = 1'b0;
      in_data[k]  = W'($urandom);
      for (int i = 0; i < a.size(); i++) begin
        if (c >= s[i] && c <= a[i]) begin
          in_valid[k] = 1'b1;
          in_data[k]  = q_words[i];
        end
      end
      #1;
      ev = 1'b0; eo = 1'b0; fs = 1'b0; fe = 1'b0; eb = 1'b0; lsb = 1'b0;
      for (int i = 0; i < a.size(); i++) begin
        if (c > a[i] && c <= a[i] + W) begin
          wi = q_words[i];
          ev = 1'b1;
          eo = wi[W - 1 - (c - a[i] - 1)];
          fs = (c == a[i] + 1);
          fe = (c == a[i] + W);
        end
        if (c > a[i] && c <= a[i] + W + g_cyc) eb = 1'b1;
        if (g_cyc == 0 && c == a[i] + W) lsb = 1'b1;
      end
      er = !eb || lsb;
      n_checks++;
      if (out_valid[k] !== ev) begin
        n_fail++;
        $display("FAIL %s_out_valid dut%0d c=%0d got=%b exp=%b", name, k, c, out_valid[k], ev);
      end
`ifndef SEQ_SERIALIZER_PRBS_IDLE_EN
      n_checks++;
      if (out[k] !== eo) begin
        n_fail++;
        $display("FAIL %s_out dut%0d c=%0d got=%b exp=%b", name, k, c, out[k], eo);
      end
`else
      if (ev) begin
        n_checks++;
        if (out[k] !== eo) begin
          n_fail++;
          $display("FAIL %s_out dut%0d c=%0d got=%b exp=%b", name, k, c, out[k], eo);
        end
      end
`endif
      n_checks++;
      if (frame_start[k] !== fs) begin
        n_fail++;
        $display("FAIL %s_frame_start dut%0d c=%0d got=%b exp=%b", name, k, c, frame_start[k], fs);
      end
      n_checks++;
      if (frame_end[k] !== fe) begin
        n_fail++;
        $display("FAIL %s_frame_end dut%0d c=%0d got=%b exp=%b", name, k, c, frame_end[k], fe);
      end
      n_checks++;
      if (busy[k] !== eb) begin
        n_fail++;
        $display("FAIL %s_busy dut%0d c=%0d got=%b exp=%b", name, k, c, busy[k], eb);
      end
      n_checks++;
      if (in_ready[k] !== er) begin
        n_fail++;
        $display("FAIL %s_in_ready dut%0d c=%0d got=%b exp=%b", name, k, c, in_ready[k], er);
      end
    end
    in_valid[k] = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      in_valid[k] = 1'b1;
      in_data[k]  = 4'b0110;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (out_valid[k] !== 1'b0 || frame_start[k] !== 1'b0 || frame_end[k] !== 1'b0 || busy[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d got valid=%b fs=%b fe=%b busy=%b exp all 0",
                 k, out_valid[k], frame_start[k], frame_end[k], busy[k]);
      end
      n_checks++;
      if (in_ready[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_in_ready dut%0d got=%b exp=1", k, in_ready[k]);
      end
`ifndef SEQ_SERIALIZER_PRBS_IDLE_EN
      n_checks++;
      if (out[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out dut%0d got=%b exp=0", k, out[k]);
      end
`endif
    end
    idle_all();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        n_checks++;
        if (out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
          n_fail++;
          $display("FAIL post_reset dut%0d got valid=%b busy=%b ready=%b exp 0/0/1",
                   k, out_valid[k], busy[k], in_ready[k]);
        end
      end
    end
  endtask

  task automatic test_single_frame();
    q_words.delete();
    q_words.push_back(4'b0110);
    run_stream(1, "single", 1'b0);
  endtask

  task automatic test_back_to_back();
    q_words.delete();
    q_words.push_back(4'b0110);
    q_words.push_back(4'b0111);
    run_stream(0, "b2b", 1'b0);
  endtask

  task automatic test_gap();
    q_words.delete();
    q_words.push_back(4'b1010);
    q_words.push_back(4'b0101);
    run_stream(2, "gap3", 1'b0);
  endtask

  task automatic test_flush();
    idle_all();
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_data[1]  = 4'b1111;
    #1;
    n_checks++;
    if (in_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_first_ready got=%b exp=1", in_ready[1]);
    end
    @(negedge clk);
    in_valid[1] = 1'b0;
    #1;
    n_checks++;
    if (out_valid[1] !== 1'b1 || out[1] !== 1'b1 || frame_start[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_bit1 got valid=%b out=%b fs=%b exp 1/1/1", out_valid[1], out[1], frame_start[1]);
    end
    @(negedge clk);
    @(negedge clk);
    flush[1]    = 1'b1;
    in_valid[1] = 1'b1;
    in_data[1]  = 4'b0110;
    #1;
    n_checks++;
    if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cycle got ready=%b valid=%b exp 0/1", in_ready[1], out_valid[1]);
    end
    @(negedge clk);
    flush[1]    = 1'b0;
    in_valid[1] = 1'b0;
    #1;
    n_checks++;
    if (out_valid[1] !== 1'b0 || frame_end[1] !== 1'b0 || busy[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_after got valid=%b fe=%b busy=%b ready=%b exp 0/0/0/1",
               out_valid[1], frame_end[1], busy[1], in_ready[1]);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid[1] !== 1'b0 || frame_start[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_accept got valid=%b fs=%b exp 0/0", out_valid[1], frame_start[1]);
    end
    q_words.delete();
    q_words.push_back(4'b0110);
    run_stream(1, "post_flush", 1'b0);
  endtask

  task automatic test_async_reset();
    idle_all();
    @(negedge clk);
    in_valid[2] = 1'b1;
    in_data[2]  = 4'b0111;
    @(negedge clk);
    in_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid[2] !== 1'b1 || out[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_bit3 got valid=%b out=%b exp 1/1", out_valid[2], out[2]);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid[2] !== 1'b0 || busy[2] !== 1'b0 || frame_start[2] !== 1'b0 || frame_end[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate got valid=%b busy=%b fs=%b fe=%b exp all 0",
               out_valid[2], busy[2], frame_start[2], frame_end[2]);
    end
`ifndef SEQ_SERIALIZER_PRBS_IDLE_EN
    n_checks++;
    if (out[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_out got=%b exp=0", out[2]);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid[2] !== 1'b0 || busy[2] !== 1'b0 || in_ready[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL areset_residual got valid=%b busy=%b ready=%b exp 0/0/1",
                 out_valid[2], busy[2], in_ready[2]);
      end
    end
  endtask

`ifdef SEQ_SERIALIZER_PRBS_IDLE_EN
  task automatic test_prbs_idle();
    logic o_seq [0:40];
    logic [W-1:0] pat;
    pat = 4'b0110;
    for (int n = 0; n < 7; n++) o_seq[n] = 1'b1;
    for (int n = 7; n <= 40; n++) o_seq[n] = o_seq[n-7] ^ o_seq[n-6];
    idle_all();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid[1] !== 1'b0 || out[1] !== o_seq[0]) begin
      n_fail++;
      $display("FAIL prbs_idle n=0 got valid=%b out=%b exp 0/%b", out_valid[1], out[1], o_seq[0]);
    end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 20) begin
        in_valid[1] = 1'b1;
        in_data[1]  = pat;
      end
      #1;
      n_checks++;
      if (out_valid[1] !== 1'b0 || out[1] !== o_seq[n]) begin
        n_fail++;
        $display("FAIL prbs_idle n=%0d got valid=%b out=%b exp 0/%b", n, out_valid[1], out[1], o_seq[n]);
      end
    end
    for (int j = 0; j < W; j++) begin
      @(negedge clk);
      in_valid[1] = 1'b0;
      #1;
      n_checks++;
      if (out_valid[1] !== 1'b1 || out[1] !== pat[W-1-j]) begin
        n_fail++;
        $display("FAIL prbs_frame j=%0d got valid=%b out=%b exp 1/%b", j, out_valid[1], out[1], pat[W-1-j]);
      end
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid[1] !== 1'b0 || out[1] !== o_seq[21+j]) begin
        n_fail++;
        $display("FAIL prbs_resume j=%0d got valid=%b out=%b exp 0/%b", j, out_valid[1], out[1], o_seq[21+j]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < NDUT; k++) begin
      q_words.delete();
      repeat (8) q_words.push_back(W'($urandom));
      run_stream(k, "random", 1'b1);
    end
  endtask

  initial begin
    idle_all();
    reset = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap();
    test_flush();
    test_async_reset();
`ifdef SEQ_SERIALIZER_PRBS_IDLE_EN
    test_prbs_idle();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
